// File: rtl/ber_pkg.sv
// Shared types, defaults and helpers for the symbol-rate BER checker.
// Imported by the decimator and the top level.
package ber_pkg;

    typedef enum logic {
        ALIGN = 1'b0,
        COUNT = 1'b1
    } ber_state_t;

    localparam int OS_DEF      = 4;
    localparam int MEM_LEN_DEF = 511;
    localparam int WIN_DEF     = 511;
    localparam int NB_CNT_MAX  = 64;

    // Increment a counter of width w (<= 64), holding at all-ones.
    function automatic logic [NB_CNT_MAX-1:0] sat_inc(
        input logic [NB_CNT_MAX-1:0] v,
        input int unsigned           w
    );
        logic [NB_CNT_MAX-1:0] mask;
        if (w >= NB_CNT_MAX)
            mask = '1;
        else
            mask = (NB_CNT_MAX'(1) << w) - NB_CNT_MAX'(1);
        return (v == mask) ? v : v + NB_CNT_MAX'(1);
    endfunction

endpackage

// File: rtl/phase_decimator.sv
// Decimates filter-rate samples to one per symbol at a selectable phase
// and slices the sign of the chosen sample into a hard bit.
module phase_decimator
    import ber_pkg::*;
#(
    parameter  int OS     = OS_DEF,
    parameter  int NBT_IN = 8,
    localparam int PW     = $clog2(OS)
) (
    input  logic              clk,
    input  logic              i_reset_n,
    input  logic              i_en,
    input  logic [NBT_IN-1:0] i_data,
    input  logic [PW-1:0]     i_phase,
    output logic              o_sym_stb,
    output logic              o_bit
);

    logic [PW-1:0] r_smp_cnt;
    logic [PW-1:0] r_phase_q;
    logic          r_bit;
    logic          w_stb;
    logic          w_last;

    assign w_stb  = i_en && (r_smp_cnt == r_phase_q);
    assign w_last = (r_smp_cnt == PW'(OS - 1));

    // Phase is only sampled at the symbol boundary so a mid-symbol
    // change never produces a short or doubled symbol period.
    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_smp_cnt <= '0;
            r_phase_q <= '0;
            r_bit     <= 1'b0;
        end else if (i_en) begin
            r_smp_cnt <= w_last ? '0 : r_smp_cnt + PW'(1);
            if (r_smp_cnt == '0)
                r_phase_q <= i_phase;
            if (w_stb)
                r_bit <= i_data[NBT_IN-1];
        end
    end

    assign o_sym_stb = w_stb;
    assign o_bit     = r_bit;

endmodule

// File: rtl/ber_checker.sv
// Bit-error checker: finds the reference latency by an exhaustive delay
// sweep, then counts compared bits and bit errors.
module ber_checker
    import ber_pkg::*;
#(
    parameter  int OS      = OS_DEF,
    parameter  int NBT_IN  = 8,
    parameter  int MEM_LEN = MEM_LEN_DEF,
    parameter  int WIN     = WIN_DEF,
    parameter  int NB_CNT  = 64,
    localparam int PW      = $clog2(OS),
    localparam int DW      = $clog2(MEM_LEN),
    localparam int WW      = $clog2(WIN + 1)
) (
    input  logic                     clk,
    input  logic                     i_reset_n,
    input  logic                     i_en,
    input  logic signed [NBT_IN-1:0] i_is_data,
    input  logic [PW-1:0]            i_phase,
    input  logic                     i_ref_bit,
    input  logic                     i_clear,
    output logic                     o_lock,
    output logic [DW-1:0]            o_delay,
    output logic [NB_CNT-1:0]        o_bit_cnt,
    output logic [NB_CNT-1:0]        o_err_cnt
);

    ber_state_t        r_state;
    ber_state_t        w_state_n;

    logic              w_sym_stb;
    logic              w_bit;
    logic              r_vld;
    logic              w_cmp;
    logic              w_align_cmp;
    logic              w_count_cmp;

    logic [MEM_LEN-1:0] r_ref_sr;
    logic [DW-1:0]      w_sel;
    logic               w_err;

    logic [DW-1:0]      r_d;
    logic [DW-1:0]      r_best_d;
    logic [DW-1:0]      r_delay;
    logic [WW-1:0]      r_win_cnt;
    logic [WW-1:0]      r_win_err;
    logic [WW-1:0]      r_min_err;
    logic [WW-1:0]      w_win_err_n;
    logic               w_win_end;
    logic               w_last_d;
    logic               w_better;

    logic [NB_CNT-1:0]     r_bit_cnt;
    logic [NB_CNT-1:0]     r_err_cnt;
    logic [NB_CNT_MAX-1:0] w_bit_inc;
    logic [NB_CNT_MAX-1:0] w_err_inc;

    phase_decimator #(
        .OS     (OS),
        .NBT_IN (NBT_IN)
    ) u_dec (
        .clk       (clk),
        .i_reset_n (i_reset_n),
        .i_en      (i_en),
        .i_data    (i_is_data),
        .i_phase   (i_phase),
        .o_sym_stb (w_sym_stb),
        .o_bit     (w_bit)
    );

    // r_vld marks a sliced bit waiting for its comparison; it is consumed
    // on the next enabled clock, after ref_sr has taken the same shift.
    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_vld    <= 1'b0;
            r_ref_sr <= '0;
        end else begin
            if (i_clear)
                r_vld <= 1'b0;
            else if (i_en)
                r_vld <= w_sym_stb;
            if (w_sym_stb)
                r_ref_sr <= {r_ref_sr[MEM_LEN-2:0], i_ref_bit};
        end
    end

    assign w_cmp       = r_vld && i_en && !i_clear;
    assign w_align_cmp = w_cmp && (r_state == ALIGN);
    assign w_count_cmp = w_cmp && (r_state == COUNT);

    assign w_sel = (r_state == COUNT) ? r_delay : r_d;
    assign w_err = w_bit ^ r_ref_sr[w_sel];

    assign w_win_err_n = r_win_err + WW'(w_err);
    assign w_win_end   = (r_win_cnt == WW'(WIN - 1));
    assign w_last_d    = (r_d == DW'(MEM_LEN - 1));
    assign w_better    = (w_win_err_n < r_min_err);

    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n)
            r_state <= ALIGN;
        else
            r_state <= w_state_n;
    end

    always_comb begin
        w_state_n = r_state;
        unique case (r_state)
            ALIGN: begin
                if (w_align_cmp && w_win_end && w_last_d)
                    w_state_n = COUNT;
            end
            COUNT:   w_state_n = COUNT;
            default: w_state_n = ALIGN;
        endcase
        if (i_clear)
            w_state_n = ALIGN;
    end

    // Strict less-than keeps the earliest delay on a tie.
    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_d       <= '0;
            r_best_d  <= '0;
            r_delay   <= '0;
            r_win_cnt <= '0;
            r_win_err <= '0;
            r_min_err <= '1;
        end else if (i_clear) begin
            r_d       <= '0;
            r_best_d  <= '0;
            r_delay   <= '0;
            r_win_cnt <= '0;
            r_win_err <= '0;
            r_min_err <= '1;
        end else if (w_align_cmp) begin
            if (w_win_end) begin
                r_win_cnt <= '0;
                r_win_err <= '0;
                if (w_better) begin
                    r_min_err <= w_win_err_n;
                    r_best_d  <= r_d;
                end
                if (w_last_d) begin
                    r_delay <= w_better ? r_d : r_best_d;
                    r_d     <= '0;
                end else begin
                    r_d <= r_d + DW'(1);
                end
            end else begin
                r_win_cnt <= r_win_cnt + WW'(1);
                r_win_err <= w_win_err_n;
            end
        end
    end

    assign w_bit_inc = sat_inc(NB_CNT_MAX'(r_bit_cnt), NB_CNT);
    assign w_err_inc = sat_inc(NB_CNT_MAX'(r_err_cnt), NB_CNT);

    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_bit_cnt <= '0;
            r_err_cnt <= '0;
        end else if (i_clear) begin
            r_bit_cnt <= '0;
            r_err_cnt <= '0;
        end else if (w_count_cmp) begin
            r_bit_cnt <= w_bit_inc[NB_CNT-1:0];
            if (w_err)
                r_err_cnt <= w_err_inc[NB_CNT-1:0];
        end
    end

    assign o_lock    = (r_state == COUNT);
    assign o_delay   = r_delay;
    assign o_bit_cnt = r_bit_cnt;
    assign o_err_cnt = r_err_cnt;

endmodule

// File: tb/tb_ber_checker.sv
// Directed bench for ber_checker: PRBS9 loopback delayed 5 symbols,
// error injection, phase switching, clear/reset, gating, saturation.
module tb_ber_checker;

    localparam int OS  = 4;
    localparam int ML  = 16;
    localparam int WN  = 32;
    localparam int DLY = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic              en;
    logic              clr;
    logic              ref_bit;
    logic signed [7:0] data;
    logic [1:0]        phase;

    logic        lock;
    logic [3:0]  dly;
    logic [63:0] bits;
    logic [63:0] errs;

    logic        lock2;
    logic [1:0]  dly2;
    logic [3:0]  bits2;
    logic [3:0]  errs2;

    ber_checker #(
        .OS(OS), .NBT_IN(8), .MEM_LEN(ML), .WIN(WN), .NB_CNT(64)
    ) u_dut (
        .clk(clk), .i_reset_n(rst_n), .i_en(en), .i_is_data(data),
        .i_phase(phase), .i_ref_bit(ref_bit), .i_clear(clr),
        .o_lock(lock), .o_delay(dly), .o_bit_cnt(bits), .o_err_cnt(errs)
    );

    // Every comparison mismatches here: constant +ve data vs ref 1.
    ber_checker #(
        .OS(OS), .NBT_IN(8), .MEM_LEN(4), .WIN(4), .NB_CNT(4)
    ) u_sat (
        .clk(clk), .i_reset_n(rst_n), .i_en(en), .i_is_data(8'sd64),
        .i_phase(phase), .i_ref_bit(1'b1), .i_clear(clr),
        .o_lock(lock2), .o_delay(dly2), .o_bit_cnt(bits2), .o_err_cnt(errs2)
    );

    typedef struct {
        int     nsym;
        int     every;
        longint xb;
        longint xe;
    } row_t;

    row_t tbl[4];

    int n_chk = 0;
    int n_err = 0;

    bit refh[16384];
    int s = 0;
    int n_en = 0;

    int  m_cnt, m_phq, m_cmp;
    bit  m_pend, m_perr, m_lock;
    longint e_bits, e_errs;
    bit  g_inv = 1'b0;
    int  g_vph = 2;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_phq = 0; m_cmp = 0;
        m_pend = 0; m_perr = 0; m_lock = 0;
        e_bits = 0; e_errs = 0;
    endtask

    task automatic samp(input bit e, input bit flip, input bit c);
        bit stb, cb, b, cmp;
        stb = e && (m_cnt == m_phq);
        cb  = (s >= DLY) ? refh[s-DLY] : 1'b0;
        b   = cb ^ (g_inv && (m_cnt != g_vph)) ^ (flip && stb);
        en      = e;
        clr     = c;
        data    = b ? -8'sd64 : 8'sd64;
        ref_bit = refh[s];
        cmp     = m_pend && e && !c;
        @(posedge clk);
        #1;
        if (e) n_en++;
        if (c) begin
            m_cmp = 0; m_lock = 0; e_bits = 0; e_errs = 0;
        end else if (cmp) begin
            if (m_lock) begin
                e_bits++;
                if (m_perr) e_errs++;
            end else begin
                m_cmp++;
                if (m_cmp == ML * WN) m_lock = 1;
            end
        end
        if (c) m_pend = 0;
        else if (e) begin
            m_pend = stb;
            m_perr = b ^ cb;
        end
        if (e) begin
            if (m_cnt == 0) m_phq = int'(phase);
            m_cnt = (m_cnt + 1) % OS;
        end
        if (stb) s++;
    endtask

    task automatic block(input bit flip);
        for (int k = 0; k < OS; k++) samp(1'b1, flip, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        en    = 1'b0;
        clr   = 1'b0;
        #1;
        chk("rst_lock", longint'(lock), 0);
        chk("rst_bits", longint'(bits), 0);
        chk("rst_errs", longint'(errs), 0);
        chk("rst_delay", longint'(dly), 0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        n_en  = 0;
    endtask

    task automatic wait_lock(input bit gated, input string name);
        int guard;
        guard = 0;
        while (!lock && guard < 20000) begin
            samp(gated ? 1'($urandom_range(0, 1)) : 1'b1, 1'b0, 1'b0);
            guard++;
        end
        chk({name, "_lock"}, longint'(lock), 1);
    endtask

    initial begin
        bit [8:0] lfsr;
        int guard;
        lfsr = 9'h1FF;
        for (int i = 0; i < 16384; i++) begin
            refh[i] = lfsr[8];
            lfsr = {lfsr[7:0], lfsr[8] ^ lfsr[4]};
        end
        tbl[0] = '{1000, 10, 1000, 100};
        tbl[1] = '{40,    0, 1040, 100};
        tbl[2] = '{20,    1, 1060, 120};
        tbl[3] = '{37,    5, 1097, 127};

        rst_n = 1'b0; en = 1'b0; clr = 1'b0;
        data = '0; ref_bit = 1'b0; phase = 2'd2;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("init_lock", longint'(lock), 0);
        chk("init_delay", longint'(dly), 0);
        chk("init_bits", longint'(bits), 0);
        chk("init_errs", longint'(errs), 0);
        chk("init_sat_bits", longint'(bits2), 0);
        rst_n = 1'b1;
        n_en  = 0;

        // Clean loopback, continuous enable.
        guard = 0;
        while (!lock && guard < 6000) begin
            samp(1'b1, 1'b0, 1'b0);
            guard++;
            if (n_en == 84) begin
                chk("sat_lock", longint'(lock2), 1);
                chk("sat_tie_delay", longint'(dly2), 0);
                chk("sat_bits_mid", longint'(bits2), 6);
                chk("sat_errs_mid", longint'(errs2), 6);
            end
        end
        chk("clean_lock", longint'(lock), 1);
        chk("clean_lock_time", n_en, 2044);
        chk("clean_delay", longint'(dly), DLY);
        chk("clean_bits0", longint'(bits), 0);
        chk("clean_errs0", longint'(errs), 0);
        chk("sat_bits_hold", longint'(bits2), 15);
        chk("sat_errs_hold", longint'(errs2), 15);

        // Error injection table.
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < tbl[r].nsym; i++)
                block(tbl[r].every != 0 && (i % tbl[r].every) == tbl[r].every - 1);
            chk($sformatf("row%0d_bits", r), longint'(bits), tbl[r].xb);
            chk($sformatf("row%0d_errs", r), longint'(errs), tbl[r].xe);
            chk($sformatf("row%0d_model", r), longint'(errs), e_errs);
        end

        // Wrong phase, then a mid-symbol switch to the right one.
        g_vph = 1; g_inv = 1'b1; phase = 2'd3;
        for (int i = 0; i < 20; i++) block(1'b0);
        samp(1'b1, 1'b0, 1'b0);
        samp(1'b1, 1'b0, 1'b0);
        phase = 2'd1;
        samp(1'b1, 1'b0, 1'b0);
        samp(1'b1, 1'b0, 1'b0);
        chk("wph_bits", longint'(bits), 1117);
        chk("wph_errs", longint'(errs), 147);
        for (int i = 0; i < 20; i++) block(1'b0);
        chk("fix_bits", longint'(bits), 1138);
        chk("fix_errs", longint'(errs), 148);
        chk("fix_model", longint'(bits), e_bits);
        g_inv = 1'b0; g_vph = 2; phase = 2'd2;
        for (int i = 0; i < 3; i++) block(1'b0);

        // Clear during COUNT, then relock.
        samp(1'b1, 1'b0, 1'b1);
        chk("clr_lock", longint'(lock), 0);
        chk("clr_bits", longint'(bits), 0);
        chk("clr_errs", longint'(errs), 0);
        wait_lock(1'b0, "relock");
        chk("relock_delay", longint'(dly), DLY);
        for (int i = 0; i < 10; i++) block(1'b0);
        chk("relock_bits", longint'(bits), 10);
        chk("relock_errs", longint'(errs), 0);

        // Asynchronous reset mid-COUNT and mid-ALIGN.
        #2;
        do_reset();
        for (int i = 0; i < 50; i++) block(1'b0);
        chk("align_nolock", longint'(lock), 0);
        #2;
        do_reset();

        // Enable gating: lock after the same number of enabled samples.
        wait_lock(1'b1, "gated");
        chk("gated_lock_time", n_en, 2044);
        chk("gated_delay", longint'(dly), DLY);
        guard = 0;
        while (n_en < 2444 && guard < 20000) begin
            samp(1'($urandom_range(0, 1)), 1'b0, 1'b0);
            guard++;
        end
        chk("gated_en_count", n_en, 2444);
        chk("gated_bits", longint'(bits), 100);
        chk("gated_errs", longint'(errs), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
